// File: rtl/dmem_mmio_slave.sv
// Zero-wait-state data-side slave: word RAM, LED/switch block and a compare timer.
// Build option MMIO_GPIO_EN adds the switch_on/led_out ports, LED register and switch synchronizer.
module dmem_mmio_slave #(
  parameter int RAM_AW = 10,
  parameter int LED_W  = 16,
  parameter int SW_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [31:0]      data_i,
  output logic [31:0]      data_o,
  output logic             timer_irq_o
`ifdef MMIO_GPIO_EN
  ,
  input  logic [SW_W-1:0]  switch_on,
  output logic [LED_W-1:0] led_out
`endif
);

  // Bus protocol: every cycle with ce=1 is exactly one complete access; there is
  // no stall. Writes commit on the next posedge, read data is valid in-cycle.

  localparam logic [5:0] REG_LED     = 6'h00;
  localparam logic [5:0] REG_SWITCH  = 6'h01;
  localparam logic [5:0] REG_COUNT   = 6'h02;
  localparam logic [5:0] REG_COMPARE = 6'h03;
  localparam logic [5:0] REG_CTRL    = 6'h04;
  localparam logic [5:0] REG_STATUS  = 6'h05;

  logic              ram_hit;
  logic              mmio_hit;
  logic              ram_sel;
  logic              mmio_sel;
  logic              illegal;
  logic              mmio_wr;
  logic [RAM_AW-1:0] ram_idx;
  logic [5:0]        reg_idx;

  logic [31:0] mem_q [0:(2**RAM_AW)-1];

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [1:0]  status_q, status_d;
  logic        match;

  logic [31:0] led_rd;
  logic [31:0] sw_rd;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];

  assign ram_hit  = (addr[31:28] == 4'h0) && ((addr[27:0] >> (RAM_AW + 2)) == 28'd0);
  assign mmio_hit = (addr[31:8] == 24'h100000);
  assign ram_sel  = ce && ram_hit;
  assign mmio_sel = ce && mmio_hit;
  assign illegal  = ce && !ram_hit && !mmio_hit;
  assign mmio_wr  = mmio_sel && we;
  assign ram_idx  = addr[RAM_AW+1:2];
  assign reg_idx  = addr[7:2];

`ifdef MMIO_GPIO_EN
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sw_s1_q;
  logic [SW_W-1:0]  sw_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= switch_on;
      sw_s2_q <= sw_s1_q;
      if (mmio_wr && reg_idx == REG_LED) led_q <= data_i[LED_W-1:0];
    end
  end

  assign led_out = led_q;
  assign led_rd  = 32'(led_q);
  assign sw_rd   = 32'(sw_s2_q);
`else
  assign led_rd  = 32'd0;
  assign sw_rd   = 32'd0;
`endif

  // RAM has no reset; a reset cycle suppresses any write presented with it.
  always_ff @(posedge clk) begin
    if (!rst && ram_sel && we) mem_q[ram_idx] <= data_i;
  end

  assign match = ctrl_q[0] && (count_q == compare_q);

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    ctrl_d    = ctrl_q;
    status_d  = status_q;
    if (ctrl_q[0]) count_d = match ? 32'd0 : count_q + 32'd1;
    if (mmio_wr) begin
      case (reg_idx)
        REG_COUNT:   count_d   = data_i;
        REG_COMPARE: compare_d = data_i;
        REG_CTRL:    ctrl_d    = data_i[1:0];
        REG_STATUS:  status_d  = status_q & ~data_i[1:0];
        default:     ;
      endcase
    end
    // New events are applied after the clear so a same-cycle set wins.
    if (match)   status_d[0] = 1'b1;
    if (illegal) status_d[1] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      ctrl_q    <= 2'd0;
      status_q  <= 2'd0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
    end
  end

  assign timer_irq_o = status_q[0] & ctrl_q[1];

  always_comb begin
    data_o = 32'd0;
    if (ram_sel && !we) begin
      data_o = mem_q[ram_idx];
    end else if (mmio_sel && !we) begin
      case (reg_idx)
        REG_LED:     data_o = led_rd;
        REG_SWITCH:  data_o = sw_rd;
        REG_COUNT:   data_o = count_q;
        REG_COMPARE: data_o = compare_q;
        REG_CTRL:    data_o = {30'd0, ctrl_q};
        REG_STATUS:  data_o = {30'd0, status_q};
        default:     data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_slave.sv
// Directed bench for dmem_mmio_slave; the GPIO checks follow the MMIO_GPIO_EN build option.
module tb_dmem_mmio_slave;

  localparam logic [31:0] A_LED     = 32'h1000_0000;
  localparam logic [31:0] A_SWITCH  = 32'h1000_0004;
  localparam logic [31:0] A_COUNT   = 32'h1000_0008;
  localparam logic [31:0] A_COMPARE = 32'h1000_000C;
  localparam logic [31:0] A_CTRL    = 32'h1000_0010;
  localparam logic [31:0] A_STATUS  = 32'h1000_0014;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        timer_irq_o;
`ifdef MMIO_GPIO_EN
  logic [15:0] switch_on;
  logic [15:0] led_out;
`endif

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  dmem_mmio_slave dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .we          (we),
    .addr        (addr),
    .data_i      (data_i),
    .data_o      (data_o),
    .timer_irq_o (timer_irq_o)
`ifdef MMIO_GPIO_EN
    ,
    .switch_on   (switch_on),
    .led_out     (led_out)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: each occupies one clock cycle, inputs change on negedge
  task automatic bus_idle();
    @(negedge clk);
    ce = 1'b0; we = 1'b0; addr = 32'd0; data_i = 32'd0;
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = a; data_i = d;
    #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = a; data_i = 32'd0;
    #1;
    d = data_o;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; ce = 1'b0; we = 1'b0; addr = 32'd0; data_i = 32'd0;
`ifdef MMIO_GPIO_EN
    switch_on = 16'h0000;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (data_o !== 32'd0) begin n_fail++; $display("FAIL reset_idle_data: got %h expected %h", data_o, 32'd0); end
    n_checks++;
    if (timer_irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", timer_irq_o); end
    bus_read(A_COMPARE, d);
    n_checks++;
    if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_compare: got %h expected ffffffff", d); end
    bus_read(A_CTRL, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", d); end
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", d); end
    bus_idle();
  endtask

  task automatic test_ram();
    logic [31:0] d;
    bus_write(32'h0000_0014, 32'h1111_1111);
    bus_write(32'h0000_0010, 32'hDEAD_BEEF);
    n_checks++;
    if (data_o !== 32'd0) begin n_fail++; $display("FAIL ram_write_data_o: got %h expected 0", data_o); end
    bus_read(32'h0000_0010, d);
    n_checks++;
    if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_b2b_read: got %h expected deadbeef", d); end
    bus_read(32'h0000_0014, d);
    n_checks++;
    if (d !== 32'h1111_1111) begin n_fail++; $display("FAIL ram_neighbour: got %h expected 11111111", d); end
    bus_write(32'h0000_0FFC, 32'hCAFE_0001);
    bus_read(32'h0000_0FFC, d);
    n_checks++;
    if (d !== 32'hCAFE_0001) begin n_fail++; $display("FAIL ram_top_word: got %h expected cafe0001", d); end
    bus_write(32'h0000_0010, 32'h0BAD_F00D);
    bus_read(32'h0000_0010, d);
    n_checks++;
    if (d !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL ram_overwrite: got %h expected 0badf00d", d); end
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL ram_no_error: got %h expected 0", d); end
    bus_idle();
  endtask

  task automatic test_illegal();
    logic [31:0] d;
    bus_write(32'h0000_0000, 32'hAAAA_5555);
    bus_write(32'h2000_0000, 32'h1234_5678);
    bus_read(32'h2000_0000, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL illegal_read_data: got %h expected 0", d); end
    bus_read(32'h0000_1000, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL illegal_above_ram: got %h expected 0", d); end
    bus_read(32'h0000_0000, d);
    n_checks++;
    if (d !== 32'hAAAA_5555) begin n_fail++; $display("FAIL illegal_ram_intact: got %h expected aaaa5555", d); end
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'd2) begin n_fail++; $display("FAIL illegal_status_set: got %h expected 2", d); end
    bus_write(A_STATUS, 32'd2);
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL illegal_status_clear: got %h expected 0", d); end
    bus_read(32'h1000_0020, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL unused_offset_read: got %h expected 0", d); end
    bus_write(32'h1000_0020, 32'hFFFF_FFFF);
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL unused_offset_no_error: got %h expected 0", d); end
    bus_idle();
  endtask

  task automatic test_timer();
    logic [31:0] d;
    logic [31:0] e;
    bus_write(A_COMPARE, 32'd5);
    bus_write(A_CTRL, 32'd3);
    for (int i = 0; i <= 5; i++) exp_q.push_back(32'(i));
    exp_q.push_back(32'd0);
    for (int i = 0; i < 7; i++) begin
      bus_read(A_COUNT, d);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== e) begin n_fail++; $display("FAIL timer_count_step%0d: got %0d expected %0d", i, d, e); end
      n_checks++;
      if (timer_irq_o !== (i == 6)) begin n_fail++; $display("FAIL timer_irq_step%0d: got %b expected %b", i, timer_irq_o, (i == 6)); end
    end
    bus_write(A_STATUS, 32'd1);
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'd0 || timer_irq_o !== 1'b0) begin n_fail++; $display("FAIL timer_w1c: got status %h irq %b expected 0 0", d, timer_irq_o); end
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL timer_count3: got %0d expected 3", d); end
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd4) begin n_fail++; $display("FAIL timer_count4: got %0d expected 4", d); end
    bus_write(A_STATUS, 32'd1);
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'd1 || timer_irq_o !== 1'b1) begin n_fail++; $display("FAIL timer_set_wins: got status %h irq %b expected 1 1", d, timer_irq_o); end
    bus_write(A_COUNT, 32'd100);
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd100) begin n_fail++; $display("FAIL timer_sw_write: got %0d expected 100", d); end
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd101) begin n_fail++; $display("FAIL timer_after_write: got %0d expected 101", d); end
    bus_write(A_STATUS, 32'd1);
    bus_write(A_COUNT, 32'd4);
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd4) begin n_fail++; $display("FAIL timer_reload4: got %0d expected 4", d); end
    bus_write(A_COUNT, 32'd50);
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd50) begin n_fail++; $display("FAIL timer_write_on_match: got %0d expected 50", d); end
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL timer_prewrite_match: got %h expected 1", d); end
    bus_write(A_CTRL, 32'd0);
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd53) begin n_fail++; $display("FAIL timer_freeze_a: got %0d expected 53", d); end
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd53) begin n_fail++; $display("FAIL timer_freeze_b: got %0d expected 53", d); end
    n_checks++;
    if (timer_irq_o !== 1'b0) begin n_fail++; $display("FAIL timer_irq_masked: got %b expected 0", timer_irq_o); end
    bus_write(A_STATUS, 32'd3);
    bus_idle();
  endtask

  task automatic test_gpio();
    logic [31:0] d;
`ifdef MMIO_GPIO_EN
    @(negedge clk);
    switch_on = 16'hA5A5;
    ce = 1'b1; we = 1'b0; addr = A_SWITCH;
    #1;
    n_checks++;
    if (data_o !== 32'd0) begin n_fail++; $display("FAIL sw_sync_0: got %h expected 0", data_o); end
    bus_read(A_SWITCH, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL sw_sync_1: got %h expected 0", d); end
    bus_read(A_SWITCH, d);
    n_checks++;
    if (d !== 32'h0000_A5A5) begin n_fail++; $display("FAIL sw_sync_2: got %h expected 0000a5a5", d); end
    bus_write(A_LED, 32'hFFFF_1234);
    bus_read(A_LED, d);
    n_checks++;
    if (led_out !== 16'h1234) begin n_fail++; $display("FAIL led_out: got %h expected 1234", led_out); end
    n_checks++;
    if (d !== 32'h0000_1234) begin n_fail++; $display("FAIL led_read: got %h expected 00001234", d); end
`else
    bus_write(A_LED, 32'h0000_1234);
    bus_read(A_LED, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL led_read_absent: got %h expected 0", d); end
    bus_read(A_SWITCH, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL sw_read_absent: got %h expected 0", d); end
`endif
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL gpio_no_error: got %h expected 0", d); end
    bus_idle();
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    bus_write(32'h0000_0020, 32'h1357_9BDF);
    bus_write(A_COMPARE, 32'd77);
    bus_write(A_CTRL, 32'd1);
    @(negedge clk);
    rst = 1'b1; ce = 1'b1; we = 1'b1; addr = 32'h0000_0020; data_i = 32'h2468_ACE0;
    @(negedge clk);
    rst = 1'b0; ce = 1'b0; we = 1'b0;
    bus_read(32'h0000_0020, d);
    n_checks++;
    if (d !== 32'h1357_9BDF) begin n_fail++; $display("FAIL reset_abort_write: got %h expected 13579bdf", d); end
    bus_read(A_COUNT, d);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_abort_count: got %0d expected 0", d); end
    bus_read(A_COMPARE, d);
    n_checks++;
    if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_abort_compare: got %h expected ffffffff", d); end
`ifdef MMIO_GPIO_EN
    n_checks++;
    if (led_out !== 16'h0000) begin n_fail++; $display("FAIL reset_abort_led: got %h expected 0", led_out); end
`endif
    bus_idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_ram();
    test_illegal();
    test_timer();
    test_gpio();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
